// File: rtl/lc3b_types.sv
// Shared LC-3b types for the CPU/cache wishbone link.
package lc3b_types;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_8words;
   typedef logic [11:0]  lc3b_line_addr;
   typedef logic [15:0]  lc3b_bytemask;
   typedef logic [1:0]   lc3b_mem_wmask;
   typedef logic [2:0]   lc3b_lane;

   typedef enum logic [1:0] {
      WB_IDLE,
      WB_REQ,
      WB_DONE
   } wb_state_e;

endpackage

// File: rtl/wb_lane_steer.sv
// Word-to-line steering: byte lane select, write replication, read extraction.
module wb_lane_steer
   import lc3b_types::*;
(
   input  lc3b_lane      lane_i,
   input  lc3b_mem_wmask be_i,
   input  lc3b_word      wdata_i,
   input  lc3b_8words    line_i,
   output lc3b_bytemask  sel_o,
   output lc3b_8words    dat_o,
   output lc3b_word      word_o
);

   assign sel_o  = {14'b0, be_i} << {lane_i, 1'b0};
   assign dat_o  = {8{wdata_i}};
   assign word_o = line_i[{lane_i, 4'b0} +: 16];

endmodule

// File: rtl/cpu_wb_master.sv
// LC-3b word port to single-line wishbone initiator with retry wait and watchdog.
module cpu_wb_master
   import lc3b_types::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          mem_read,
   input  logic          mem_write,
   input  lc3b_word      mem_address,
   input  lc3b_word      mem_wdata,
   input  lc3b_mem_wmask mem_byte_enable,
   output logic          mem_resp,
   output lc3b_word      mem_rdata,
   output logic          timeout_err,
   output lc3b_line_addr wb_adr,
   output lc3b_8words    wb_dat_m,
   output lc3b_bytemask  wb_sel,
   output logic          wb_cyc,
   output logic          wb_stb,
   output logic          wb_we,
   input  lc3b_8words    wb_dat_s,
   input  logic          wb_ack,
   input  logic          wb_rty
);

   wb_state_e     state_q, state_d;
   logic          cyc_q, cyc_d;
   logic          we_q, we_d;
   lc3b_line_addr adr_q, adr_d;
   lc3b_bytemask  sel_q, sel_d;
   lc3b_8words    dat_q, dat_d;
   lc3b_lane      lane_q, lane_d;
   logic [31:0]   cnt_q, cnt_d;
   lc3b_word      rdata_q, rdata_d;
   logic          terr_q, terr_d;

   lc3b_lane      st_lane;
   lc3b_bytemask  st_sel;
   lc3b_8words    st_dat;
   lc3b_word      st_word;

   // In IDLE the steering sees the live request; afterwards the captured lane.
   assign st_lane = (state_q == WB_IDLE) ? mem_address[3:1] : lane_q;

   wb_lane_steer u_steer (
      .lane_i  (st_lane),
      .be_i    (mem_byte_enable),
      .wdata_i (mem_wdata),
      .line_i  (wb_dat_s),
      .sel_o   (st_sel),
      .dat_o   (st_dat),
      .word_o  (st_word)
   );

   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      we_d    = we_q;
      adr_d   = adr_q;
      sel_d   = sel_q;
      dat_d   = dat_q;
      lane_d  = lane_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      terr_d  = terr_q;
      unique case (state_q)
         WB_IDLE: begin
            if (mem_read | mem_write) begin
               lane_d = mem_address[3:1];
               adr_d  = mem_address[15:4];
               cnt_d  = '0;
               if (mem_write && (mem_byte_enable == 2'b00)) begin
                  state_d = WB_DONE;
               end else begin
                  state_d = WB_REQ;
                  cyc_d   = 1'b1;
                  we_d    = mem_write;
                  sel_d   = mem_write ? st_sel : 16'hFFFF;
                  dat_d   = st_dat;
               end
            end
         end
         WB_REQ: begin
            if (wb_ack) begin
               cyc_d   = 1'b0;
               we_d    = 1'b0;
               state_d = WB_DONE;
               if (!we_q) rdata_d = st_word;
            end else if ((TIMEOUT_CYCLES != 0) &&
                         (cnt_q == TIMEOUT_CYCLES - 1)) begin
               cyc_d   = 1'b0;
               we_d    = 1'b0;
               rdata_d = '0;
               terr_d  = 1'b1;
               state_d = WB_DONE;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         WB_DONE: state_d = WB_IDLE;
         default: state_d = WB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= WB_IDLE;
         cyc_q   <= 1'b0;
         we_q    <= 1'b0;
         adr_q   <= '0;
         sel_q   <= '0;
         dat_q   <= '0;
         lane_q  <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         sel_q   <= sel_d;
         dat_q   <= dat_d;
         lane_q  <= lane_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         terr_q  <= terr_d;
      end
   end

   assign wb_cyc      = cyc_q;
   assign wb_stb      = cyc_q;
   assign wb_we       = we_q;
   assign wb_adr      = adr_q;
   assign wb_sel      = sel_q;
   assign wb_dat_m    = dat_q;
   assign mem_resp    = (state_q == WB_DONE);
   assign mem_rdata   = rdata_q;
   assign timeout_err = terr_q;

endmodule
